flxx_fetch_seq: RTL and testbench
=================================

# flxx_fetch_seq

Multi-cycle fetch/decode/writeback sequencer for the flxx core; the upstream and downstream partner of the instruction handler. Fetches 32-bit instruction words over a request/valid memory port, owns the PC and a 32×32 register file, and decodes each word into `itype`/`opcode`/`reg1`/`reg2` for the handler. Captures the handler's `outval`/`jmp` to perform register writeback and PC redirect. Runs one instruction at a time; there is no pipelining.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word aligned.
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equal to PC.
- `imem_rdata`  in  32  instruction word; valid when `imem_valid`=1.
- `imem_valid`  in  1  fetch response strobe.
- `itype`  out  2  handler instruction type.
- `opcode`  out  5  handler opcode.
- `reg1`  out  32  handler operand 1.
- `reg2`  out  32  handler operand 2.
- `outval`  in  32  handler result.
- `jmp`  in  1  handler branch-taken flag.
- `pc`  out  32  current PC.
- `halted`  out  1  sequencer is in HALT.

## Operation
- Word fields: `[31:30]` itype. itype 00 and 10: `[29:25]` opcode, `[24:20]` rd, `[19:15]` rs1. itype 00: `[14:10]` rs2, `[9:0]` off10. itype 10: `[14:0]` imm15. itype 01: `[28:24]` rd; `[23:0]` are passed as `reg2` = {8'b0, imm24}. itype 11: HALT.
- Operands: `reg1` = R[rs1] for itypes 00 and 10, otherwise 0. `reg2` = R[rs2] (itype 00), sign-extended imm15 (itype 10), or {8'b0, w[23:0]} (itype 01).
- Branch class: itype ∈ {00,10} with opcode[4:3]=2'b10. Writes no register.
  - itype 00 taken target = PC + (sext(off10) << 2).
  - itype 10 taken target = R[rd] & ~32'h3.
  - Not taken: PC + 4.
- Reserved class: opcode[4:3]=2'b11. Treated as NOP: no writeback, PC + 4.
- ALU class: opcode[4]=0, plus all itype 01. Writes R[rd] <= `outval`; PC + 4.
- `jmp` is sampled only for the branch class and ignored otherwise.
- HALT: no writeback, PC unchanged. The sequencer stays in HALT until reset.
- States:
  - RESET → FETCH.
  - FETCH → DECODE on `imem_valid`.
  - DECODE → EXEC.
  - EXEC → WB.
  - WB → FETCH, or → HALT if itype = 11.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 0.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`pc`=RESET_PC.
  - `itype`=0, `opcode`=0, `reg1`=0, `reg2`=0.
  - `halted`=0; all registers 0; state FETCH.
- FETCH:
  - `imem_req`=1, with `imem_addr` held stable until the cycle `imem_valid`=1 is sampled.
  - The word is latched on that edge, and `imem_req` is 0 in the next cycle.
  - `imem_valid` outside FETCH is ignored.
- DECODE: register reads complete; handler inputs are registered and become valid at the start of EXEC.
- EXEC: handler inputs stay stable; `outval`/`jmp` are captured at the end of EXEC.
- WB: register write and PC update take effect at the end of WB.
- Latency:
  - Minimum 4 cycles per instruction, when `imem_valid` arrives in the first FETCH cycle.
  - Each cycle of fetch wait adds one cycle.
- An instruction in DECODE sees the register written by the previous WB; there is no hazard.
- Reset asserted in any state, including mid-fetch or HALT, aborts on that edge: no writeback, and all outputs return to reset values.
- `halted` rises at the end of WB for a HALT word.

## Configuration
- `FLXX_ZERO_REG_EN` defined:
  - R0 reads as 0 always.
  - Writes with rd=0 are discarded.
  - itype 10 indirect branch via R0 targets address 0.
- `FLXX_ZERO_REG_EN` undefined: R0 is an ordinary read/write register.

## Test plan
- Reset with RESET_PC=32'h100, then `imem_valid` on the first FETCH cycle -> `imem_addr`=32'h100; next fetch is at 32'h104 exactly 4 cycles later.
- ALU word itype 00, opcode 5'b00001, rd=3, rs1=1, rs2=2, with R1=5, R2=7, and the handler model returning 12 -> `reg1`=5, `reg2`=7 during EXEC; R3=12 after WB.
- itype 00 branch with off10=10'h3FE (-2), PC=32'h20, `jmp`=1 -> next `imem_addr`=32'h18. The same word with `jmp`=0 -> 32'h24, and no register changes.
- itype 01 with rd=4 and w[23:0]=24'h80_0001 -> `reg2`=32'h0080_0001; R4 = handler `outval`.
- `imem_valid` delayed 3 cycles, then rst_n=0 asserted during the following DECODE -> no writeback; `pc`=RESET_PC; `imem_req`=0 on the cycle after reset.
- HALT word -> `halted`=1; `imem_req` stays 0 for at least 20 cycles. With `FLXX_ZERO_REG_EN`, a write to rd=0 of 32'hDEAD reads back 0.

Source files
------------

// File: rtl/flxx_fetch_seq_if.sv
// flxx_fetch_seq_if: instruction-memory port and instruction-handler port
// of the flxx fetch/decode/writeback sequencer.
interface flxx_fetch_seq_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            imem_valid;
    logic [1:0]      itype;
    logic [4:0]      opcode;
    logic [XLEN-1:0] reg1;
    logic [XLEN-1:0] reg2;
    logic [XLEN-1:0] outval;
    logic            jmp;

    // Sequencer side
    modport master (
        output imem_req, imem_addr, itype, opcode, reg1, reg2,
        input  imem_rdata, imem_valid, outval, jmp
    );

    // Memory / handler side
    modport slave (
        input  imem_req, imem_addr, itype, opcode, reg1, reg2,
        output imem_rdata, imem_valid, outval, jmp
    );
endinterface

// File: rtl/flxx_fetch_seq.sv
// flxx_fetch_seq: non-pipelined FETCH/DECODE/EXEC/WB sequencer for the flxx
// core. Owns the PC and a 32x32 register file, decodes each fetched word
// into handler operands, and applies the handler result / branch decision.
// Optional feature macro: FLXX_ZERO_REG_EN (R0 hard-wired to zero).
module flxx_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    flxx_fetch_seq_if.master bus,
    output logic [31:0]      pc,
    output logic             halted
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned RIDX = 5;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_WB     = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ir;
    logic            r_req;
    logic [1:0]      r_itype;
    logic [4:0]      r_opcode;
    logic [XLEN-1:0] r_reg1;
    logic [XLEN-1:0] r_reg2;
    logic [XLEN-1:0] r_outval;
    logic            r_jmp;
    logic            r_is_br;
    logic            r_is_halt;
    logic            r_wb_en;
    logic [RIDX-1:0] r_wb_rd;
    logic [XLEN-1:0] r_br_tgt;
    logic            r_halted;
    logic [XLEN-1:0] r_rf [NREG];

    logic [1:0]      w_itype;
    logic            w_dual;
    logic [4:0]      w_opcode;
    logic [RIDX-1:0] w_rd;
    logic [RIDX-1:0] w_rs1;
    logic [RIDX-1:0] w_rs2;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic [XLEN-1:0] w_rd_val;
    logic [XLEN-1:0] w_reg1;
    logic [XLEN-1:0] w_reg2;
    logic            w_is_br;
    logic            w_is_halt;
    logic            w_wb_en;
    logic [XLEN-1:0] w_br_tgt;
    logic            w_rf_we;

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_pc;
    assign bus.itype     = r_itype;
    assign bus.opcode    = r_opcode;
    assign bus.reg1      = r_reg1;
    assign bus.reg2      = r_reg2;
    assign pc            = r_pc;
    assign halted        = r_halted;

    // Decode the latched word: fields, register reads, class and branch target
    always_comb begin
        w_itype  = r_ir[31:30];
        // itype 00 and 10 share the opcode/rd/rs1 layout
        w_dual   = ~r_ir[30];
        w_opcode = w_dual ? r_ir[29:25] : 5'd0;
        w_rd     = (w_itype == 2'b01) ? r_ir[28:24] : r_ir[24:20];
        w_rs1    = r_ir[19:15];
        w_rs2    = r_ir[14:10];
`ifdef FLXX_ZERO_REG_EN
        w_rs1_val = (w_rs1 == '0) ? '0 : r_rf[w_rs1];
        w_rs2_val = (w_rs2 == '0) ? '0 : r_rf[w_rs2];
        w_rd_val  = (w_rd  == '0) ? '0 : r_rf[w_rd];
`else
        w_rs1_val = r_rf[w_rs1];
        w_rs2_val = r_rf[w_rs2];
        w_rd_val  = r_rf[w_rd];
`endif
        w_reg1 = w_dual ? w_rs1_val : '0;
        case (w_itype)
            2'b00:   w_reg2 = w_rs2_val;
            2'b10:   w_reg2 = {{17{r_ir[14]}}, r_ir[14:0]};
            2'b01:   w_reg2 = {8'h00, r_ir[23:0]};
            default: w_reg2 = '0;
        endcase
        w_is_br   = w_dual && (r_ir[29:28] == 2'b10);
        w_is_halt = (w_itype == 2'b11);
        // Reserved opcodes (11xxx) fall out of both branch and ALU classes
        w_wb_en   = (w_itype == 2'b01) || (w_dual && !r_ir[29]);
        if (w_itype == 2'b00) begin
            w_br_tgt = r_pc + {{20{r_ir[9]}}, r_ir[9:0], 2'b00};
        end else begin
            w_br_tgt = {w_rd_val[31:2], 2'b00};
        end
    end

    // Register-file write enable, qualified in WB only
    always_comb begin
        w_rf_we = (r_state == ST_WB) && r_wb_en;
`ifdef FLXX_ZERO_REG_EN
        if (r_wb_rd == '0) begin
            w_rf_we = 1'b0;
        end
`endif
    end

    // Register file: cleared on reset, written at the end of WB
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf <= '{default: '0};
        end else if (w_rf_we) begin
            r_rf[r_wb_rd] <= r_outval;
        end
    end

    // Sequencer FSM with registered memory/handler outputs and PC
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_req     <= 1'b0;
            r_itype   <= '0;
            r_opcode  <= '0;
            r_reg1    <= '0;
            r_reg2    <= '0;
            r_outval  <= '0;
            r_jmp     <= 1'b0;
            r_is_br   <= 1'b0;
            r_is_halt <= 1'b0;
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_br_tgt  <= '0;
            r_halted  <= 1'b0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.imem_valid) begin
                        r_ir    <= bus.imem_rdata;
                        r_req   <= 1'b0;
                        r_state <= ST_DECODE;
                    end else begin
                        r_req   <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_itype   <= w_itype;
                    r_opcode  <= w_opcode;
                    r_reg1    <= w_reg1;
                    r_reg2    <= w_reg2;
                    r_is_br   <= w_is_br;
                    r_is_halt <= w_is_halt;
                    r_wb_en   <= w_wb_en;
                    r_wb_rd   <= w_rd;
                    r_br_tgt  <= w_br_tgt;
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_outval <= bus.outval;
                    r_jmp    <= bus.jmp & r_is_br;
                    r_state  <= ST_WB;
                end
                ST_WB: begin
                    if (r_is_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_pc    <= r_jmp ? r_br_tgt : r_pc + 32'd4;
                        r_req   <= 1'b1;
                        r_state <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_flxx_fetch_seq.sv
// tb_flxx_fetch_seq: directed, table-driven bench for flxx_fetch_seq with a
// few hand-written multi-cycle sequences (mid-fetch reset, HALT).
module tb_flxx_fetch_seq;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          NV     = 18;
`ifdef FLXX_ZERO_REG_EN
    localparam logic [31:0] R0_AFTER_WR = 32'h0000_0000;
`else
    localparam logic [31:0] R0_AFTER_WR = 32'h0000_DEAD;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        halted;
    logic [31:0] cur_pc;
    int          total = 0;
    int          bad   = 0;

    flxx_fetch_seq_if bus_if ();

    flxx_fetch_seq #(.RESET_PC(RST_PC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus_if),
        .pc     (pc),
        .halted (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          wait_cyc;
        logic [31:0] outval;
        logic        jmp;
        logic [1:0]  e_itype;
        logic [4:0]  e_op;
        logic [31:0] e_reg1;
        logic [31:0] e_reg2;
        logic [31:0] e_next;
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [31:0] enc_r(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [9:0] off);
        return {2'b00, op, rd, rs1, rs2, off};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [14:0] imm);
        return {2'b10, op, rd, rs1, imm};
    endfunction

    function automatic logic [31:0] enc_u(input logic [4:0] rd, input logic [23:0] imm);
        return {2'b01, 1'b0, rd, imm};
    endfunction

    function automatic void setv(input int i, input logic [31:0] w, input int wc,
                                 input logic [31:0] o, input logic j, input logic [1:0] it,
                                 input logic [4:0] op, input logic [31:0] r1,
                                 input logic [31:0] r2, input logic [31:0] nx);
        vecs[i].word     = w;
        vecs[i].wait_cyc = wc;
        vecs[i].outval   = o;
        vecs[i].jmp      = j;
        vecs[i].e_itype  = it;
        vecs[i].e_op     = op;
        vecs[i].e_reg1   = r1;
        vecs[i].e_reg2   = r2;
        vecs[i].e_next   = nx;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    // One full instruction: fetch wait, latch, check EXEC operands, check next PC
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        for (int w = 0; w < v.wait_cyc; w++) begin
            bus_if.imem_valid = 1'b0;
            @(posedge clk); #1;
            check("fetch_req", i, 32'(bus_if.imem_req), 32'd1);
            check("fetch_addr_hold", i, bus_if.imem_addr, cur_pc);
        end
        bus_if.imem_rdata = v.word;
        bus_if.imem_valid = 1'b1;
        @(posedge clk); #1;
        // DECODE: stray response with a junk word must be ignored
        bus_if.imem_rdata = 32'hFFFF_FFFF;
        check("decode_req", i, 32'(bus_if.imem_req), 32'd0);
        bus_if.imem_valid = 1'b0;
        @(posedge clk); #1;
        // EXEC
        check("itype", i, 32'(bus_if.itype), 32'(v.e_itype));
        if (v.e_itype != 2'b01) check("opcode", i, 32'(bus_if.opcode), 32'(v.e_op));
        check("reg1", i, bus_if.reg1, v.e_reg1);
        check("reg2", i, bus_if.reg2, v.e_reg2);
        bus_if.outval     = v.outval;
        bus_if.jmp        = v.jmp;
        bus_if.imem_valid = 1'b1;
        @(posedge clk); #1;
        // WB: handler result lines change; sequencer must use the EXEC-end capture
        bus_if.outval     = ~v.outval;
        bus_if.jmp        = ~v.jmp;
        bus_if.imem_valid = 1'b0;
        bus_if.imem_rdata = 32'h0;
        @(posedge clk); #1;
        bus_if.jmp = 1'b0;
        check("next_addr", i, bus_if.imem_addr, v.e_next);
        check("next_pc", i, pc, v.e_next);
        check("next_req", i, 32'(bus_if.imem_req), 32'd1);
        cur_pc = v.e_next;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus_if.imem_valid = 1'b0;
        bus_if.imem_rdata = 32'h0;
        bus_if.outval     = 32'h0;
        bus_if.jmp        = 1'b0;
        cur_pc            = RST_PC;

        setv( 0, enc_u(5'd1, 24'h000005),             0, 32'h5,         1'b0, 2'b01, 5'h00, 32'h0,    32'h5,         32'h104);
        setv( 1, enc_u(5'd2, 24'h000007),             0, 32'h7,         1'b0, 2'b01, 5'h00, 32'h0,    32'h7,         32'h108);
        setv( 2, enc_r(5'h01, 5'd3, 5'd1, 5'd2, 10'h0), 2, 32'd12,      1'b0, 2'b00, 5'h01, 32'h5,    32'h7,         32'h10C);
        setv( 3, enc_r(5'h01, 5'd6, 5'd3, 5'd3, 10'h0), 0, 32'h0,       1'b0, 2'b00, 5'h01, 32'd12,   32'd12,        32'h110);
        setv( 4, enc_u(5'd4, 24'h800001),             0, 32'h1234,      1'b0, 2'b01, 5'h00, 32'h0,    32'h0080_0001, 32'h114);
        setv( 5, enc_i(5'h02, 5'd7, 5'd4, 15'h7FFF),  1, 32'h55,        1'b0, 2'b10, 5'h02, 32'h1234, 32'hFFFF_FFFF, 32'h118);
        setv( 6, enc_u(5'd5, 24'h000023),             0, 32'h23,        1'b0, 2'b01, 5'h00, 32'h0,    32'h23,        32'h11C);
        setv( 7, enc_i(5'h10, 5'd5, 5'd4, 15'h0),     0, 32'hBAD,       1'b1, 2'b10, 5'h10, 32'h1234, 32'h0,         32'h20);
        setv( 8, enc_r(5'h11, 5'd0, 5'd5, 5'd7, 10'h3FE), 0, 32'hDEAD,  1'b1, 2'b00, 5'h11, 32'h23,   32'h55,        32'h18);
        setv( 9, enc_i(5'h18, 5'd2, 5'd0, 15'h4000),  0, 32'h77,        1'b1, 2'b10, 5'h18, 32'h0,    32'hFFFF_C000, 32'h1C);
        setv(10, enc_r(5'h11, 5'd0, 5'd2, 5'd0, 10'h3FE), 0, 32'h99,    1'b0, 2'b00, 5'h11, 32'h7,    32'h0,         32'h20);
        setv(11, enc_r(5'h11, 5'd0, 5'd5, 5'd7, 10'h3FE), 0, 32'hDEAD,  1'b0, 2'b00, 5'h11, 32'h23,   32'h55,        32'h24);
        setv(12, enc_r(5'h0F, 5'd0, 5'd0, 5'd0, 10'h0), 0, 32'hDEAD,    1'b0, 2'b00, 5'h0F, 32'h0,    32'h0,         32'h28);
        setv(13, enc_r(5'h00, 5'd8, 5'd0, 5'd0, 10'h0), 0, 32'h0,       1'b0, 2'b00, 5'h00, R0_AFTER_WR, R0_AFTER_WR, 32'h2C);
        setv(14, enc_u(5'd9, 24'h0),                  0, 32'hFFFF_FFFC, 1'b0, 2'b01, 5'h00, 32'h0,    32'h0,         32'h30);
        setv(15, enc_i(5'h17, 5'd9, 5'd1, 15'h0),     0, 32'h0,         1'b1, 2'b10, 5'h17, 32'h5,    32'h0,         32'hFFFF_FFFC);
        setv(16, enc_u(5'd10, 24'h000001),            0, 32'h1,         1'b0, 2'b01, 5'h00, 32'h0,    32'h1,         32'h0);
        // Used after the mid-fetch reset: R1 and R9 must be back to 0
        setv(17, enc_r(5'h01, 5'd11, 5'd1, 5'd9, 10'h0), 0, 32'h0,      1'b0, 2'b00, 5'h01, 32'h0,    32'h0,         32'h104);

        repeat (2) @(posedge clk);
        #1;
        check("rst_req",    0, 32'(bus_if.imem_req), 32'd0);
        check("rst_addr",   0, bus_if.imem_addr, RST_PC);
        check("rst_pc",     0, pc, RST_PC);
        check("rst_itype",  0, 32'(bus_if.itype), 32'd0);
        check("rst_opcode", 0, 32'(bus_if.opcode), 32'd0);
        check("rst_reg1",   0, bus_if.reg1, 32'd0);
        check("rst_reg2",   0, bus_if.reg2, 32'd0);
        check("rst_halted", 0, 32'(halted), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(i);

        // Delayed response, then reset while the word sits in DECODE
        bus_if.imem_rdata = enc_u(5'd1, 24'h0000AA);
        bus_if.imem_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("late_req", 0, 32'(bus_if.imem_req), 32'd1);
        bus_if.imem_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.imem_valid = 1'b0;
        rst_n             = 1'b0;
        bus_if.outval     = 32'hAAAA;
        @(posedge clk); #1;
        check("abort_pc",     0, pc, RST_PC);
        check("abort_addr",   0, bus_if.imem_addr, RST_PC);
        check("abort_req",    0, 32'(bus_if.imem_req), 32'd0);
        check("abort_itype",  0, 32'(bus_if.itype), 32'd0);
        check("abort_reg2",   0, bus_if.reg2, 32'd0);
        check("abort_halted", 0, 32'(halted), 32'd0);
        rst_n  = 1'b1;
        cur_pc = RST_PC;
        run_vec(17);

        // HALT word
        bus_if.imem_rdata = 32'hC000_0000;
        bus_if.imem_valid = 1'b1;
        @(posedge clk); #1;
        bus_if.imem_valid = 1'b0;
        check("halt_decode_req", 0, 32'(bus_if.imem_req), 32'd0);
        @(posedge clk); #1;
        check("halt_itype", 0, 32'(bus_if.itype), 32'd3);
        @(posedge clk); #1;
        check("halt_wb_halted", 0, 32'(halted), 32'd0);
        @(posedge clk); #1;
        check("halted", 0, 32'(halted), 32'd1);
        check("halt_req", 0, 32'(bus_if.imem_req), 32'd0);
        check("halt_pc", 0, pc, 32'h104);
        for (int c = 0; c < 20; c++) begin
            bus_if.imem_rdata = enc_u(5'd1, 24'h1);
            bus_if.imem_valid = 1'b1;
            @(posedge clk); #1;
            check("halt_hold_req", c, 32'(bus_if.imem_req), 32'd0);
            check("halt_hold_halted", c, 32'(halted), 32'd1);
        end
        bus_if.imem_valid = 1'b0;
        check("halt_hold_pc", 0, pc, 32'h104);

        rst_n = 1'b0;
        @(posedge clk); #1;
        check("halt_rst_halted", 0, 32'(halted), 32'd0);
        check("halt_rst_pc", 0, pc, RST_PC);
        check("halt_rst_req", 0, 32'(bus_if.imem_req), 32'd0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
